// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-channel sequential binary-to-BCD converter.
// A single shift-and-add-3 engine walks through CHANNELS binary values,
// one input bit per clock, and publishes all results together with a
// one-cycle done pulse. Values that need more than DIGITS decimal digits
// are reported modulo 10^DIGITS with a per-channel overflow flag.
module bin2bcd_seq #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 3
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [CHANNELS*BIN_W-1:0]    bin_in,
    output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
    output logic [CHANNELS-1:0]          overflow,
    output logic                         done,
    output logic                         busy
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIN_W - 1);
    localparam logic [CH_W-1:0]  LAST_CHAN = CH_W'(CHANNELS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Request shadow and engine state
    logic [CHANNELS*BIN_W-1:0] shadow_q;
    logic [BIN_W-1:0]          bin_sr_q;
    logic [BCD_W-1:0]          acc_q;
    logic                      sticky_q;
    logic [CNT_W-1:0]          bit_cnt_q;
    logic [CH_W-1:0]           chan_q;

    // Per-channel result slots, filled as each channel completes
    logic [CHANNELS*BCD_W-1:0] slots_q;
    logic [CHANNELS-1:0]       ovf_slots_q;

    logic                      accept;
    logic                      chan_end;
    logic                      last_chan;
    logic [BCD_W-1:0]          acc_adj;
    logic [BCD_W-1:0]          acc_shift;
    logic                      carry_out;
    logic [CHANNELS*BCD_W-1:0] slots_d;
    logic [CHANNELS-1:0]       ovf_slots_d;
    logic [BIN_W-1:0]          next_bin;

    // Add 3 to every digit that would reach 10 or more after doubling.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = a[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Select one channel of the shadow register with constant slices only.
    function automatic logic [BIN_W-1:0] channel_of(input logic [CHANNELS*BIN_W-1:0] v,
                                                    input logic [CH_W-1:0]           idx);
        logic [BIN_W-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (idx == CH_W'(c)) begin
                r = v[c*BIN_W +: BIN_W];
            end
        end
        return r;
    endfunction

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == CONV);
    assign accept      = start_valid && start_ready;
    assign chan_end    = (state_q == CONV) && (bit_cnt_q == LAST_BIT);
    assign last_chan   = (chan_q == LAST_CHAN);

    // One double-dabble step: correct digits, then shift the next binary bit in.
    assign acc_adj   = dabble_adjust(acc_q);
    assign acc_shift = {acc_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
    assign carry_out = acc_adj[BCD_W-1];
    assign next_bin  = channel_of(shadow_q, chan_q + 1'b1);

    // Merge the channel finishing this cycle into its result slot.
    always_comb begin
        slots_d     = slots_q;
        ovf_slots_d = ovf_slots_q;
        if (chan_end) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_q == CH_W'(c)) begin
                    slots_d[c*BCD_W +: BCD_W] = acc_shift;
                    ovf_slots_d[c]            = sticky_q | carry_out;
                end
            end
        end
    end

    // Next-state logic: leave IDLE on accept, return after the last channel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (chan_end && last_chan) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion engine, result slots and registered outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            shadow_q    <= '0;
            bin_sr_q    <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            bit_cnt_q   <= '0;
            chan_q      <= '0;
            slots_q     <= '0;
            ovf_slots_q <= '0;
            bcd_out     <= '0;
            overflow    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shadow_q  <= bin_in;
                bin_sr_q  <= bin_in[BIN_W-1:0];
                acc_q     <= '0;
                sticky_q  <= 1'b0;
                bit_cnt_q <= '0;
                chan_q    <= '0;
            end else if (state_q == CONV) begin
                slots_q     <= slots_d;
                ovf_slots_q <= ovf_slots_d;
                if (chan_end) begin
                    bit_cnt_q <= '0;
                    acc_q     <= '0;
                    sticky_q  <= 1'b0;
                    if (last_chan) begin
                        bcd_out  <= slots_d;
                        overflow <= ovf_slots_d;
                        done     <= 1'b1;
                    end else begin
                        chan_q   <= chan_q + 1'b1;
                        bin_sr_q <= next_bin;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    acc_q     <= acc_shift;
                    bin_sr_q  <= bin_sr_q << 1;
                    sticky_q  <= sticky_q | carry_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (defaults, 2-digit
// overflow variant, 16-bit single channel) share clock and reset.
module tb_bin2bcd_seq;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [63:0] bcd;
        logic [7:0]  ovf;
        int          acc_cyc;
    } exp_t;

    logic        CLK;
    logic        rst;
    logic        rst_q = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        sv      [NI];
    logic [63:0] bin_d   [NI];
    logic        rdy_w   [NI];
    logic        done_w  [NI];
    logic        busy_w  [NI];
    logic [63:0] bcd_w   [NI];
    logic [7:0]  ovf_w   [NI];
    logic [63:0] held_bcd[NI];
    logic [7:0]  held_ovf[NI];
    int          acc_cnt [NI];

    exp_t        q[$];

    logic [35:0] bcd0;  logic [2:0] ovf0;  logic rdy0, done0, busy0;
    logic [23:0] bcd1;  logic [2:0] ovf1;  logic rdy1, done1, busy1;
    logic [19:0] bcd2;  logic [0:0] ovf2;  logic rdy2, done2, busy2;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .CHANNELS(3)) dut0 (
        .CLK(CLK), .rst(rst), .start_valid(sv[0]), .start_ready(rdy0),
        .bin_in(bin_d[0][23:0]), .bcd_out(bcd0), .overflow(ovf0),
        .done(done0), .busy(busy0)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .CHANNELS(3)) dut1 (
        .CLK(CLK), .rst(rst), .start_valid(sv[1]), .start_ready(rdy1),
        .bin_in(bin_d[1][23:0]), .bcd_out(bcd1), .overflow(ovf1),
        .done(done1), .busy(busy1)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .CHANNELS(1)) dut2 (
        .CLK(CLK), .rst(rst), .start_valid(sv[2]), .start_ready(rdy2),
        .bin_in(bin_d[2][15:0]), .bcd_out(bcd2), .overflow(ovf2),
        .done(done2), .busy(busy2)
    );

    always_comb begin
        rdy_w[0] = rdy0;  done_w[0] = done0;  busy_w[0] = busy0;
        bcd_w[0] = 64'(bcd0);  ovf_w[0] = 8'(ovf0);
        rdy_w[1] = rdy1;  done_w[1] = done1;  busy_w[1] = busy1;
        bcd_w[1] = 64'(bcd1);  ovf_w[1] = 8'(ovf1);
        rdy_w[2] = rdy2;  done_w[2] = done2;  busy_w[2] = busy2;
        bcd_w[2] = 64'(bcd2);  ovf_w[2] = 8'(ovf2);
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic int bw_of(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic int dig_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 2 : 5);
    endfunction

    function automatic int ch_of(input int k);
        return (k == 2) ? 1 : 3;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 2) ? 16 : 24;
    endfunction

    // Reference: decimal digits of value mod 10^DIGITS, overflow when value >= 10^DIGITS.
    function automatic void model(input int k, input logic [63:0] b,
                                  output logic [63:0] e_bcd, output logic [7:0] e_ovf);
        longint unsigned lim;
        longint unsigned v;
        longint unsigned r;
        int bw;
        int dg;
        bw = bw_of(k);
        dg = dig_of(k);
        lim = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        e_bcd = '0;
        e_ovf = '0;
        for (int c = 0; c < ch_of(k); c++) begin
            v = (b >> (c * bw)) & ((64'd1 << bw) - 64'd1);
            e_ovf[c] = (v >= lim);
            r = v % lim;
            for (int d = 0; d < dg; d++) begin
                e_bcd[(c*dg + d)*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
    endfunction

    function automatic logic [63:0] pack3(input int a, input int b, input int c, input int bw);
        return 64'(a) | (64'(b) << bw) | (64'(c) << (2 * bw));
    endfunction

    function automatic int pending(input int k);
        int n;
        n = 0;
        foreach (q[i]) if (q[i].inst == k) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on done, checks holds and reset state,
    // and records each accepted request with its model result.
    always @(negedge CLK) begin
        for (int k = 0; k < NI; k++) begin
            int   idx;
            exp_t e;
            if (rst_q) begin
                chk("rst_bcd", bcd_w[k], 64'd0);
                chk("rst_ovf", 64'(ovf_w[k]), 64'd0);
                chk("rst_done", 64'(done_w[k]), 64'd0);
                chk("rst_busy", 64'(busy_w[k]), 64'd0);
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].inst == k) q.delete(i);
                end
                held_bcd[k] = '0;
                held_ovf[k] = '0;
            end else begin
                chk("ready_vs_busy", 64'(rdy_w[k]), 64'(!busy_w[k]));
                if (done_w[k]) begin
                    idx = -1;
                    for (int i = 0; i < q.size(); i++) begin
                        if (idx < 0 && q[i].inst == k) idx = i;
                    end
                    if (idx < 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done inst=%0d: actual=1 expected=0 t=%0t", k, $time);
                    end else begin
                        chk("bcd", bcd_w[k], q[idx].bcd);
                        chk("ovf", 64'(ovf_w[k]), 64'(q[idx].ovf));
                        chk("latency", 64'(cyc - q[idx].acc_cyc), 64'(lat_of(k)));
                        held_bcd[k] = q[idx].bcd;
                        held_ovf[k] = q[idx].ovf;
                        q.delete(idx);
                    end
                end else begin
                    chk("hold_bcd", bcd_w[k], held_bcd[k]);
                    chk("hold_ovf", 64'(ovf_w[k]), 64'(held_ovf[k]));
                end
            end
            if (sv[k] && rdy_w[k] && !rst) begin
                e.inst = k;
                model(k, bin_d[k], e.bcd, e.ovf);
                e.acc_cyc = cyc + 1;
                q.push_back(e);
                acc_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input int k, input logic [63:0] b);
        int n;
        n = 0;
        while (!rdy_w[k] && n < 200) begin
            step();
            n++;
        end
        chk("ready_wait", 64'(rdy_w[k]), 64'd1);
        sv[k]    = 1'b1;
        bin_d[k] = b;
        step();
        sv[k]    = 1'b0;
        bin_d[k] = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (pending(k) > 0 && n < 400) begin
            step();
            n++;
        end
        chk("drain", 64'(pending(k)), 64'd0);
    endtask

    initial begin
        int n;
        int a0;
        for (int k = 0; k < NI; k++) begin
            sv[k] = 1'b0;
            bin_d[k] = '0;
            acc_cnt[k] = 0;
            held_bcd[k] = '0;
            held_ovf[k] = '0;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("idle_ready", 64'(rdy_w[0]), 64'd1);
        chk("idle_busy", 64'(busy_w[0]), 64'd0);
        chk("idle_bcd", bcd_w[0], 64'd0);

        // Basic conversion and latency
        request(0, pack3(59, 7, 23, 8));
        wait_idle(0);

        // Back-to-back request accepted in the done cycle
        request(0, pack3(255, 0, 100, 8));
        n = 0;
        while (!done_w[0] && n < 60) begin
            step();
            n++;
        end
        chk("wait_done", 64'(done_w[0]), 64'd1);
        chk("b2b_ready", 64'(rdy_w[0]), 64'd1);
        sv[0] = 1'b1;
        bin_d[0] = pack3(9, 10, 99, 8);
        step();
        sv[0] = 1'b0;
        chk("b2b_busy", 64'(busy_w[0]), 64'd1);
        wait_idle(0);

        // start_valid held high with bin_in changing every cycle
        a0 = acc_cnt[0];
        sv[0] = 1'b1;
        for (int i = 0; i < 72; i++) begin
            bin_d[0] = 64'($urandom);
            step();
        end
        sv[0] = 1'b0;
        chk("accepts_per_window", 64'(acc_cnt[0] - a0), 64'd3);
        wait_idle(0);

        // Randomised requests
        for (int i = 0; i < 15; i++) begin
            request(0, pack3($urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 255), 8));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(0);

        // Reset in the middle of a conversion
        request(0, pack3(200, 201, 202, 8));
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy_w[0]), 64'd0);
        chk("abort_ready", 64'(rdy_w[0]), 64'd1);
        chk("abort_bcd", bcd_w[0], 64'd0);
        repeat (30) step();
        rst = 1'b1;
        sv[0] = 1'b1;
        bin_d[0] = pack3(1, 2, 3, 8);
        step();
        rst = 1'b0;
        sv[0] = 1'b0;
        chk("rst_beats_start", 64'(busy_w[0]), 64'd0);
        request(0, pack3(45, 30, 12, 8));
        wait_idle(0);

        // Two-digit variant: overflow flags
        request(1, pack3(99, 100, 200, 8));
        wait_idle(1);
        for (int i = 0; i < 6; i++) begin
            request(1, pack3($urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 255), 8));
        end
        wait_idle(1);

        // 16-bit single channel variant
        request(2, 64'd65535);
        wait_idle(2);
        request(2, 64'd0);
        wait_idle(2);
        for (int i = 0; i < 6; i++) begin
            request(2, 64'($urandom_range(0, 65535)));
        end
        wait_idle(2);

        repeat (5) step();
        chk("leftover", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
